// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - picoMips program counter sequencer with fetch handshake and return-address stack
//
// Purpose: owns the PC register, issues instruction fetches, and picks the next
// PC from increment, relative branch, absolute jump, call or return.
//
// Ports:
//   Clock           in   single clock, all state changes on posedge
//   Reset           in   synchronous active-high reset
//   FetchReq        out  fetch request for address ProgramCounter (FETCH state)
//   FetchAck        in   instruction delivered; control inputs valid this cycle
//   Branch          in   conditional branch instruction
//   BranchTaken     in   branch condition true (only meaningful with Branch)
//   BranchOffset    in   signed displacement, OFFSET_WIDTH bits
//   Jump            in   absolute jump to JumpTarget
//   Call            in   push return address, go to JumpTarget
//   Return          in   pop return address into PC
//   JumpTarget      in   absolute target for Jump/Call
//   Halt            in   stop fetching until Reset
//   ProgramCounter  out  current instruction address (registered)
//   StackCount      out  number of valid return-address entries
//   StackError      out  sticky overflow/underflow flag
//   Halted          out  high in HALT state
module pc_sequencer #(
    parameter int PC_WIDTH     = 7,
    parameter int OFFSET_WIDTH = 8,
    parameter int STACK_DEPTH  = 4,
    localparam int SC_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    output logic                    FetchReq,
    input  logic                    FetchAck,
    input  logic                    Branch,
    input  logic                    BranchTaken,
    input  logic [OFFSET_WIDTH-1:0] BranchOffset,
    input  logic                    Jump,
    input  logic                    Call,
    input  logic                    Return,
    input  logic [PC_WIDTH-1:0]     JumpTarget,
    input  logic                    Halt,
    output logic [PC_WIDTH-1:0]     ProgramCounter,
    output logic [SC_WIDTH-1:0]     StackCount,
    output logic                    StackError,
    output logic                    Halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n;
    logic [SC_WIDTH-1:0] count, count_n;
    logic                err, err_n;
    logic                push;

    // Sized to the full index range of count so indexing needs no width
    // adaptation; only the low STACK_DEPTH entries are ever written.
    logic [PC_WIDTH-1:0] stack_mem [2**SC_WIDTH];

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_branch;
    logic [SC_WIDTH-1:0] top_idx;
    logic                stack_empty;
    logic                stack_full;

    assign pc_inc      = pc + PC_WIDTH'(1);
    // Size cast of a signed value sign-extends or truncates to PC width,
    // so the add is naturally modulo 2^PC_WIDTH.
    assign pc_branch   = pc + PC_WIDTH'($signed(BranchOffset));
    assign top_idx     = count - SC_WIDTH'(1);
    assign stack_empty = (count == '0);
    assign stack_full  = (count == SC_WIDTH'(STACK_DEPTH));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
            pc    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            count <= count_n;
            err   <= err_n;
        end
    end

    // Stack contents carry no reset; only the count defines validity.
    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            stack_mem[count] <= pc_inc;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        count_n = count;
        err_n   = err;
        push    = 1'b0;
        case (state)
            S_IDLE: begin
                state_n = S_FETCH;
            end
            S_FETCH: begin
                if (FetchAck) begin
                    if (Halt) begin
                        state_n = S_HALT;
                    end else if (Return) begin
                        if (!stack_empty) begin
                            pc_n    = stack_mem[top_idx];
                            count_n = top_idx;
                        end else begin
                            pc_n  = pc_inc;
                            err_n = 1'b1;
                        end
                    end else if (Call) begin
                        // Overflowing call still transfers control.
                        pc_n = JumpTarget;
                        if (!stack_full) begin
                            push    = 1'b1;
                            count_n = count + SC_WIDTH'(1);
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (Jump) begin
                        pc_n = JumpTarget;
                    end else if (Branch && BranchTaken) begin
                        pc_n = pc_branch;
                    end else begin
                        pc_n = pc_inc;
                    end
                end
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign FetchReq       = (state == S_FETCH);
    assign Halted         = (state == S_HALT);
    assign ProgramCounter = pc;
    assign StackCount     = count;
    assign StackError     = err;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam int PW   = 7;
    localparam int OW   = 8;
    localparam int SD   = 4;
    localparam int SCW  = $clog2(SD + 1);
    localparam int MASK = (1 << PW) - 1;

    logic           Clock = 1'b0;
    logic           Reset;
    logic           FetchAck, Branch, BranchTaken, Jump, Call, Return, Halt;
    logic [OW-1:0]  BranchOffset;
    logic [PW-1:0]  JumpTarget;
    logic           FetchReq, StackError, Halted;
    logic [PW-1:0]  ProgramCounter;
    logic [SCW-1:0] StackCount;

    pc_sequencer #(.PC_WIDTH(PW), .OFFSET_WIDTH(OW), .STACK_DEPTH(SD)) dut (
        .Clock(Clock), .Reset(Reset), .FetchReq(FetchReq), .FetchAck(FetchAck),
        .Branch(Branch), .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
        .Jump(Jump), .Call(Call), .Return(Return), .JumpTarget(JumpTarget),
        .Halt(Halt), .ProgramCounter(ProgramCounter), .StackCount(StackCount),
        .StackError(StackError), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = idle, 1 = fetching, 2 = halted
    int m_state;
    int m_pc;
    int m_stk[$];
    bit m_err;

    typedef struct {
        logic       ack, halt, ret, call, jump, br, tk;
        logic [7:0] off;
        logic [6:0] jt;
        int         pc;
        int         cnt;
        bit         err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        int off;
        if (Reset) begin
            m_state = 0; m_pc = 0; m_err = 0;
            m_stk.delete();
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 && FetchAck) begin
            if (Halt) begin
                m_state = 2;
            end else if (Return) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = (m_pc + 1) & MASK; m_err = 1; end
            end else if (Call) begin
                if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) & MASK);
                else m_err = 1;
                m_pc = int'(JumpTarget);
            end else if (Jump) begin
                m_pc = int'(JumpTarget);
            end else if (Branch && BranchTaken) begin
                off  = int'($signed(BranchOffset));
                m_pc = (m_pc + off) & MASK;
            end else begin
                m_pc = (m_pc + 1) & MASK;
            end
        end
    endtask

    task automatic compare_all(string tag);
        check({tag, ".fetchreq"}, 32'(FetchReq), 32'(m_state == 1));
        check({tag, ".halted"}, 32'(Halted), 32'(m_state == 2));
        check({tag, ".pc"}, 32'(ProgramCounter), m_pc);
        check({tag, ".count"}, 32'(StackCount), m_stk.size());
        check({tag, ".err"}, 32'(StackError), 32'(m_err));
    endtask

    task automatic step(string tag);
        @(posedge Clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic ack, halt, ret, call, jump, br, tk,
                         input logic [7:0] off, input logic [6:0] jt);
        FetchAck = ack; Halt = halt; Return = ret; Call = call; Jump = jump;
        Branch = br; BranchTaken = tk; BranchOffset = off; JumpTarget = jt;
    endtask

    task automatic add(input logic ack, halt, ret, call, jump, br, tk,
                       input logic [7:0] off, input logic [6:0] jt,
                       input int pc, input int cnt, input bit err);
        vec_t v;
        v.ack = ack; v.halt = halt; v.ret = ret; v.call = call; v.jump = jump;
        v.br = br; v.tk = tk; v.off = off; v.jt = jt;
        v.pc = pc; v.cnt = cnt; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 8'd0, 7'd0);
        step("reset");
        Reset = 1'b0;
    endtask

    initial begin
        // ack halt ret call jump br tk off jt -> pc cnt err
        add(1,0,0,0,1,0,0, 8'd0,   7'd10, 10, 0, 0);
        add(1,0,0,0,0,1,1, 8'hFC,  7'd0,   6, 0, 0);
        add(1,0,0,0,1,0,0, 8'd0,   7'd10, 10, 0, 0);
        add(1,0,0,0,0,1,0, 8'd3,   7'd0,  11, 0, 0);
        add(1,0,0,0,0,0,1, 8'd3,   7'd0,  12, 0, 0);
        add(1,0,0,0,1,0,0, 8'd0,   7'd2,   2, 0, 0);
        add(1,0,0,0,0,1,1, 8'hFB,  7'd0, 125, 0, 0);
        add(1,0,0,0,1,0,0, 8'd0,   7'd5,   5, 0, 0);
        add(0,0,0,0,1,0,0, 8'd0,   7'd40,  5, 0, 0);
        add(0,0,0,0,1,0,0, 8'd0,   7'd40,  5, 0, 0);
        add(0,0,0,0,1,0,0, 8'd0,   7'd40,  5, 0, 0);
        add(1,0,0,0,1,0,0, 8'd0,   7'd40, 40, 0, 0);
        add(1,0,0,0,1,0,0, 8'd0,   7'd20, 20, 0, 0);
        add(1,0,0,1,0,0,0, 8'd0,   7'd50, 50, 1, 0);
        add(1,0,1,0,0,0,0, 8'd0,   7'd0,  21, 0, 0);
        add(1,0,0,1,0,0,0, 8'd0,   7'd60, 60, 1, 0);
        add(1,0,0,1,0,0,0, 8'd0,   7'd61, 61, 2, 0);
        add(1,0,0,1,0,0,0, 8'd0,   7'd62, 62, 3, 0);
        add(1,0,0,1,0,0,0, 8'd0,   7'd63, 63, 4, 0);
        add(1,0,0,1,0,0,0, 8'd0,   7'd64, 64, 4, 1);
        add(1,0,1,0,0,0,0, 8'd0,   7'd0,  63, 3, 1);
        add(1,0,1,0,0,0,0, 8'd0,   7'd0,  62, 2, 1);
        add(1,0,1,0,0,0,0, 8'd0,   7'd0,  61, 1, 1);
        add(1,0,1,0,0,0,0, 8'd0,   7'd0,  22, 0, 1);
        add(1,0,1,0,0,0,0, 8'd0,   7'd0,  23, 0, 1);
        add(1,0,0,1,1,0,0, 8'd0,   7'd80, 80, 1, 1);
        add(1,0,1,1,0,0,0, 8'd0,   7'd90, 24, 0, 1);
        add(1,0,0,0,1,1,1, 8'd5,   7'd30, 30, 0, 1);
        add(1,0,0,0,0,1,1, 8'd100, 7'd0,   2, 0, 1);
        add(1,0,0,0,1,0,0, 8'd0,  7'd127,127, 0, 1);
        add(1,0,0,1,0,0,0, 8'd0,   7'd10, 10, 1, 1);
        add(1,0,1,0,0,0,0, 8'd0,   7'd0,   0, 0, 1);
        add(1,0,0,0,1,0,0, 8'd0,  7'd127,127, 0, 1);
        add(1,0,0,0,0,0,0, 8'd0,   7'd0,   0, 0, 1);

        // Reset values and IDLE occupancy
        do_reset();
        check("rst_pc", 32'(ProgramCounter), 0);
        check("rst_fetchreq", 32'(FetchReq), 0);
        check("rst_halted", 32'(Halted), 0);
        check("rst_count", 32'(StackCount), 0);
        check("rst_err", 32'(StackError), 0);
        step("idle");
        check("first_fetchreq", 32'(FetchReq), 1);

        // Free-running increment with wrap
        drive(1, 0, 0, 0, 0, 0, 0, 8'd0, 7'd0);
        for (int i = 0; i < 130; i++) step("wrap");
        check("wrap_pc", 32'(ProgramCounter), 2);

        // Directed table
        do_reset();
        step("idle");
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ack, tbl[i].halt, tbl[i].ret, tbl[i].call, tbl[i].jump,
                  tbl[i].br, tbl[i].tk, tbl[i].off, tbl[i].jt);
            step("tbl");
            check($sformatf("tbl%0d.pc", i), 32'(ProgramCounter), tbl[i].pc);
            check($sformatf("tbl%0d.cnt", i), 32'(StackCount), tbl[i].cnt);
            check($sformatf("tbl%0d.err", i), 32'(StackError), 32'(tbl[i].err));
        end

        // Halt beats Call and Jump; HALT ignores further Acks
        drive(1, 0, 0, 1, 0, 0, 0, 8'd0, 7'd33);
        step("pre_halt");
        drive(1, 1, 0, 1, 1, 0, 0, 8'd0, 7'd99);
        step("halt");
        check("halt_pc", 32'(ProgramCounter), 33);
        check("halt_halted", 32'(Halted), 1);
        check("halt_fetchreq", 32'(FetchReq), 0);
        check("halt_count", 32'(StackCount), 1);
        drive(1, 0, 1, 1, 1, 1, 1, 8'd7, 7'd11);
        for (int i = 0; i < 3; i++) step("halted");
        check("halted_pc", 32'(ProgramCounter), 33);
        check("halted_count", 32'(StackCount), 1);

        // Reset out of HALT
        Reset = 1'b1;
        step("rst_halt");
        check("rst_halt_pc", 32'(ProgramCounter), 0);
        check("rst_halt_halted", 32'(Halted), 0);
        check("rst_halt_count", 32'(StackCount), 0);
        check("rst_halt_err", 32'(StackError), 0);
        check("rst_halt_fetchreq", 32'(FetchReq), 0);
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 8'd0, 7'd0);
        step("idle");

        // Reset in the middle of a stall, with Ack and Call also present
        drive(1, 0, 0, 1, 0, 0, 0, 8'd0, 7'd5);
        step("pre_stall");
        drive(0, 0, 0, 0, 1, 0, 0, 8'd0, 7'd40);
        step("stall");
        step("stall");
        check("stall_pc", 32'(ProgramCounter), 5);
        Reset = 1'b1;
        drive(1, 0, 0, 1, 0, 0, 0, 8'd0, 7'd40);
        step("rst_stall");
        check("rst_stall_pc", 32'(ProgramCounter), 0);
        check("rst_stall_count", 32'(StackCount), 0);
        check("rst_stall_fetchreq", 32'(FetchReq), 0);
        Reset = 1'b0;

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            Reset        = ($urandom_range(0, 99) == 0);
            FetchAck     = ($urandom_range(0, 3) != 0);
            Halt         = ($urandom_range(0, 59) == 0);
            Return       = ($urandom_range(0, 4) == 0);
            Call         = ($urandom_range(0, 4) == 0);
            Jump         = ($urandom_range(0, 5) == 0);
            Branch       = ($urandom_range(0, 2) == 0);
            BranchTaken  = 1'($urandom_range(0, 1));
            BranchOffset = 8'($urandom);
            JumpTarget   = 7'($urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
